// File: rtl/pps_div_pkg.sv
// Shared definitions for the multi-channel PPS divider: channel state
// encodings, default timing constant and packed-bus slice helpers.
package pps_div_pkg;

  localparam int CLKS_PER_US_DEF = 10;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARM   = 3'd1;
  localparam logic [2:0] ST_PHASE = 3'd2;
  localparam logic [2:0] ST_WIDTH = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  // LSB index of channel k's field in a packed bus of W-bit fields
  function automatic int slice_lsb(input int k, input int w);
    return k * w;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int ctr_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pps_div_channel.sv
// One divider channel: FSM, microsecond prescaler, phase/width/edge/pulse
// counters, shadow configuration registers and status outputs.
module pps_div_channel
  import pps_div_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int PHASE_WIDTH = 32,
  parameter int CLKS_PER_US = CLKS_PER_US_DEF
) (
  input  logic                   i_clk_10,
  input  logic                   i_rst,
  input  logic                   i_pps_edge,
  input  logic                   i_start,
  input  logic                   i_stop,
  input  logic                   i_invert,
  input  logic [DATA_WIDTH-1:0]  i_div,
  input  logic [PHASE_WIDTH-1:0] i_phase,
  input  logic [DATA_WIDTH-1:0]  i_width,
  input  logic [DATA_WIDTH-1:0]  i_burst,
  output logic                   o_pps_div,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_overrun
);

  localparam int                     PW         = ctr_bits(CLKS_PER_US);
  localparam logic [PW-1:0]          PRESC_LAST = PW'(CLKS_PER_US - 1);
  localparam logic [PW-1:0]          PRESC_ONE  = PW'(1);
  localparam logic [DATA_WIDTH-1:0]  D_ONE      = DATA_WIDTH'(1);
  localparam logic [PHASE_WIDTH-1:0] P_ONE      = PHASE_WIDTH'(1);

  logic [2:0]             state_q, state_d;
  logic [DATA_WIDTH-1:0]  sh_div, sh_width, sh_burst;
  logic [PHASE_WIDTH-1:0] sh_phase;
  logic [PW-1:0]          presc;
  logic [PHASE_WIDTH-1:0] phase_ctr;
  logic [DATA_WIDTH-1:0]  wctr, edge_ctr, pulses_ctr;
  logic                   overrun_q, out_q;

  logic [DATA_WIDTH-1:0]  div_eff, width_nx;
  logic                   edge_hit, presc_wrap, fire;
  logic                   phase_done, width_done, burst_done, pulse_d;

  // Next-state and event decode; the output flop is fed from the next state
  // so the pulse rises in the same edge that enters WIDTH.
  always_comb begin
    div_eff    = (sh_div == '0) ? D_ONE : sh_div;
    edge_hit   = i_pps_edge && (edge_ctr >= div_eff - D_ONE);
    presc_wrap = (presc == PRESC_LAST);
    fire       = (i_pps_edge && state_q == ST_ARM) ||
                 (edge_hit && state_q == ST_WAIT);
    phase_done = (state_q == ST_PHASE) && presc_wrap &&
                 (phase_ctr >= sh_phase - P_ONE);
    width_done = (state_q == ST_WIDTH) &&
                 ((sh_width == '0) || (presc_wrap && wctr >= sh_width - D_ONE));
    burst_done = (sh_burst != '0) && (pulses_ctr >= sh_burst - D_ONE);

    state_d = state_q;
    if (i_stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:          if (i_start) state_d = ST_ARM;
        ST_ARM, ST_WAIT:  if (fire) state_d = (i_phase != '0) ? ST_PHASE : ST_WIDTH;
        ST_PHASE:         if (phase_done) state_d = ST_WIDTH;
        ST_WIDTH:         if (width_done) state_d = burst_done ? ST_DONE : ST_WAIT;
        ST_DONE:          if (!i_start) state_d = ST_IDLE;
        default:          state_d = ST_IDLE;
      endcase
    end

    width_nx = fire ? i_width : sh_width;
    pulse_d  = (state_d == ST_WIDTH) && (width_nx != '0);
  end

  // State, counters, shadows and sticky overrun
  always_ff @(posedge i_clk_10 or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= ST_IDLE;
      out_q      <= 1'b0;
      overrun_q  <= 1'b0;
      sh_div     <= '0;
      sh_phase   <= '0;
      sh_width   <= '0;
      sh_burst   <= '0;
      presc      <= '0;
      phase_ctr  <= '0;
      wctr       <= '0;
      edge_ctr   <= '0;
      pulses_ctr <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= pulse_d ^ i_invert;
      if (i_stop) begin
        presc      <= '0;
        phase_ctr  <= '0;
        wctr       <= '0;
        edge_ctr   <= '0;
        pulses_ctr <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (state_d == ST_ARM) begin
              overrun_q  <= 1'b0;
              pulses_ctr <= '0;
              edge_ctr   <= '0;
            end
          end
          ST_ARM, ST_WAIT: begin
            if (fire) begin
              sh_div    <= i_div;
              sh_phase  <= i_phase;
              sh_width  <= i_width;
              sh_burst  <= i_burst;
              edge_ctr  <= '0;
              presc     <= '0;
              phase_ctr <= '0;
              wctr      <= '0;
            end else if (i_pps_edge && state_q == ST_WAIT) begin
              edge_ctr <= edge_ctr + D_ONE;
            end
          end
          ST_PHASE, ST_WIDTH: begin
            // A firing edge here cannot restart the pulse; it is only flagged.
            if (i_pps_edge) begin
              if (edge_hit) begin
                edge_ctr  <= '0;
                overrun_q <= 1'b1;
              end else begin
                edge_ctr <= edge_ctr + D_ONE;
              end
            end
            presc <= presc_wrap ? '0 : presc + PRESC_ONE;
            if (state_q == ST_PHASE) begin
              if (presc_wrap) phase_ctr <= phase_ctr + P_ONE;
              if (phase_done) begin
                presc <= '0;
                wctr  <= '0;
              end
            end else begin
              if (presc_wrap) wctr <= wctr + D_ONE;
              if (width_done) begin
                presc <= '0;
                if (pulses_ctr != '1) pulses_ctr <= pulses_ctr + D_ONE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_pps_div = out_q;
  assign o_busy    = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign o_done    = (state_q == ST_DONE);
  assign o_overrun = overrun_q;

endmodule

// File: rtl/pps_divider_multi.sv
// N-channel PPS divider: shared PPS synchroniser and rising-edge detector
// feeding N_CH independent pps_div_channel instances.
// Optional build macro PPS_DIVIDER_MULTI_INVERT_EN adds i_invert (per-channel
// output polarity); without it the outputs are active-high only.
// SYNC_STAGES must be at least 2.
module pps_divider_multi
  import pps_div_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int PHASE_WIDTH = 32,
  parameter int CLKS_PER_US = CLKS_PER_US_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          i_clk_10,
  input  logic                          i_rst,
  input  logic                          i_pps_raw,
  input  logic [N_CH-1:0]               i_start,
  input  logic [N_CH-1:0]               i_stop,
`ifdef PPS_DIVIDER_MULTI_INVERT_EN
  input  logic [N_CH-1:0]               i_invert,
`endif
  input  logic [N_CH*DATA_WIDTH-1:0]    i_div_number,
  input  logic [N_CH*PHASE_WIDTH-1:0]   i_phase_us,
  input  logic [N_CH*DATA_WIDTH-1:0]    i_width_us,
  input  logic [N_CH*DATA_WIDTH-1:0]    i_burst_cnt,
  output logic [N_CH-1:0]               o_pps_div,
  output logic [N_CH-1:0]               o_busy,
  output logic [N_CH-1:0]               o_done,
  output logic [N_CH-1:0]               o_overrun
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   pps_edge;
  logic [N_CH-1:0]        invert;

`ifdef PPS_DIVIDER_MULTI_INVERT_EN
  assign invert = i_invert;
`else
  assign invert = '0;
`endif

  // PPS synchroniser chain followed by the edge-history flop
  always_ff @(posedge i_clk_10 or negedge i_rst) begin
    if (!i_rst) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_pps_raw};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pps_edge = sync_q[SYNC_STAGES-1] & ~edge_q;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    localparam int LD = slice_lsb(k, DATA_WIDTH);
    localparam int LP = slice_lsb(k, PHASE_WIDTH);

    pps_div_channel #(
      .DATA_WIDTH (DATA_WIDTH),
      .PHASE_WIDTH(PHASE_WIDTH),
      .CLKS_PER_US(CLKS_PER_US)
    ) u_ch (
      .i_clk_10  (i_clk_10),
      .i_rst     (i_rst),
      .i_pps_edge(pps_edge),
      .i_start   (i_start[k]),
      .i_stop    (i_stop[k]),
      .i_invert  (invert[k]),
      .i_div     (i_div_number[LD +: DATA_WIDTH]),
      .i_phase   (i_phase_us[LP +: PHASE_WIDTH]),
      .i_width   (i_width_us[LD +: DATA_WIDTH]),
      .i_burst   (i_burst_cnt[LD +: DATA_WIDTH]),
      .o_pps_div (o_pps_div[k]),
      .o_busy    (o_busy[k]),
      .o_done    (o_done[k]),
      .o_overrun (o_overrun[k])
    );
  end

endmodule

// File: tb/tb_pps_divider_multi.sv
// Directed bench for pps_divider_multi: reset, periodic, burst, overrun,
// stop, asynchronous reset and zero-width/zero-divide channels.
module tb_pps_divider_multi;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int PHW = 32;

  logic             i_clk_10  = 1'b0;
  logic             i_rst     = 1'b0;
  logic             i_pps_raw = 1'b0;
  logic [N-1:0]     i_start   = '0;
  logic [N-1:0]     i_stop    = '0;
  logic [N*DW-1:0]  i_div_number = '0;
  logic [N*PHW-1:0] i_phase_us   = '0;
  logic [N*DW-1:0]  i_width_us   = '0;
  logic [N*DW-1:0]  i_burst_cnt  = '0;
  logic [N-1:0]     o_pps_div, o_busy, o_done, o_overrun;

  pps_divider_multi dut (
    .i_clk_10    (i_clk_10),
    .i_rst       (i_rst),
    .i_pps_raw   (i_pps_raw),
    .i_start     (i_start),
    .i_stop      (i_stop),
`ifdef PPS_DIVIDER_MULTI_INVERT_EN
    .i_invert    ('0),
`endif
    .i_div_number(i_div_number),
    .i_phase_us  (i_phase_us),
    .i_width_us  (i_width_us),
    .i_burst_cnt (i_burst_cnt),
    .o_pps_div   (o_pps_div),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_overrun   (o_overrun)
  );

  always #5 i_clk_10 = ~i_clk_10;

  int cyc = 0;
  always @(posedge i_clk_10) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int pps_r[8];

  // Pulse monitor: rise cycle and high length per channel
  int rise_tab[N][8];
  int len_tab[N][8];
  int rise_n[N];
  int len_n[N];
  int rise_at[N];
  logic [N-1:0] prev_o = '0;

  always @(negedge i_clk_10) begin
    for (int k = 0; k < N; k++) begin
      if (o_pps_div[k] === 1'b1 && prev_o[k] === 1'b0) begin
        rise_at[k] = cyc;
        if (rise_n[k] < 8) rise_tab[k][rise_n[k]] = cyc;
        rise_n[k]++;
      end
      if (o_pps_div[k] === 1'b0 && prev_o[k] === 1'b1) begin
        if (len_n[k] < 8) len_tab[k][len_n[k]] = cyc - rise_at[k];
        len_n[k]++;
      end
    end
    prev_o = o_pps_div;
  end

  task automatic clear_mon();
    for (int k = 0; k < N; k++) begin
      rise_n[k] = 0;
      len_n[k]  = 0;
    end
  endtask

  task automatic set_cfg(input int ch, input int dv, input int ph, input int wd, input int bu);
    i_div_number[ch*DW +: DW] = DW'(dv);
    i_phase_us[ch*PHW +: PHW] = PHW'(ph);
    i_width_us[ch*DW +: DW]   = DW'(wd);
    i_burst_cnt[ch*DW +: DW]  = DW'(bu);
  endtask

  task automatic do_reset();
    @(negedge i_clk_10);
    i_rst = 1'b0; i_start = '0; i_stop = '0; i_pps_raw = 1'b0;
    i_div_number = '0; i_phase_us = '0; i_width_us = '0; i_burst_cnt = '0;
    repeat (3) @(negedge i_clk_10);
    i_rst = 1'b1;
    @(negedge i_clk_10);
    clear_mon();
  endtask

  // n raw PPS pulses, period cycles apart; raw rise cycles go to pps_r[base+i]
  task automatic pps_train(input int n, input int period, input int base);
    for (int i = 0; i < n; i++) begin
      @(negedge i_clk_10);
      pps_r[base+i] = cyc;
      i_pps_raw = 1'b1;
      repeat (5) @(negedge i_clk_10);
      i_pps_raw = 1'b0;
      repeat (period - 6) @(negedge i_clk_10);
    end
  endtask

  task automatic test_reset();
    @(negedge i_clk_10);
    i_rst = 1'b0;
    set_cfg(0, 1, 0, 5, 0);
    i_start = '1;
    repeat (2) @(negedge i_clk_10);
    tests++; if (o_pps_div !== 4'b0) begin fails++; $display("FAIL reset_out: got %b expected %b", o_pps_div, 4'b0); end
    tests++; if (o_busy !== 4'b0) begin fails++; $display("FAIL reset_busy: got %b expected %b", o_busy, 4'b0); end
    tests++; if (o_done !== 4'b0) begin fails++; $display("FAIL reset_done: got %b expected %b", o_done, 4'b0); end
    tests++; if (o_overrun !== 4'b0) begin fails++; $display("FAIL reset_overrun: got %b expected %b", o_overrun, 4'b0); end
    i_start = '0;
    i_rst = 1'b1;
    repeat (3) @(negedge i_clk_10);
    tests++; if (o_busy !== 4'b0) begin fails++; $display("FAIL idle_after_reset: got %b expected %b", o_busy, 4'b0); end
  endtask

  task automatic test_periodic();
    do_reset();
    set_cfg(0, 1, 0, 5, 0);
    i_start[0] = 1'b1;
    repeat (5) @(negedge i_clk_10);
    pps_train(4, 1000, 0);
    tests++; if (rise_n[0] !== 4) begin fails++; $display("FAIL periodic_count: got %0d expected %0d", rise_n[0], 4); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (rise_tab[0][i] !== pps_r[i] + 3) begin fails++; $display("FAIL periodic_rise%0d: got %0d expected %0d", i, rise_tab[0][i], pps_r[i] + 3); end
      tests++; if (len_tab[0][i] !== 50) begin fails++; $display("FAIL periodic_len%0d: got %0d expected %0d", i, len_tab[0][i], 50); end
    end
    tests++; if (o_busy[0] !== 1'b1) begin fails++; $display("FAIL periodic_busy: got %b expected %b", o_busy[0], 1'b1); end
  endtask

  task automatic test_burst();
    do_reset();
    set_cfg(1, 3, 2, 1, 2);
    i_start[1] = 1'b1;
    repeat (5) @(negedge i_clk_10);
    pps_train(6, 200, 0);
    tests++; if (rise_n[1] !== 2) begin fails++; $display("FAIL burst_count: got %0d expected %0d", rise_n[1], 2); end
    tests++; if (rise_tab[1][0] !== pps_r[0] + 23) begin fails++; $display("FAIL burst_rise0: got %0d expected %0d", rise_tab[1][0], pps_r[0] + 23); end
    tests++; if (rise_tab[1][1] !== pps_r[3] + 23) begin fails++; $display("FAIL burst_rise1: got %0d expected %0d", rise_tab[1][1], pps_r[3] + 23); end
    tests++; if (len_tab[1][0] !== 10) begin fails++; $display("FAIL burst_len0: got %0d expected %0d", len_tab[1][0], 10); end
    tests++; if (len_tab[1][1] !== 10) begin fails++; $display("FAIL burst_len1: got %0d expected %0d", len_tab[1][1], 10); end
    tests++; if (o_done[1] !== 1'b1) begin fails++; $display("FAIL burst_done: got %b expected %b", o_done[1], 1'b1); end
    tests++; if (o_busy[1] !== 1'b0) begin fails++; $display("FAIL burst_busy: got %b expected %b", o_busy[1], 1'b0); end
  endtask

  task automatic test_overrun();
    do_reset();
    set_cfg(2, 1, 150, 1, 0);
    i_start[2] = 1'b1;
    repeat (5) @(negedge i_clk_10);
    pps_train(1, 1000, 0);
    tests++; if (o_overrun[2] !== 1'b0) begin fails++; $display("FAIL overrun_early: got %b expected %b", o_overrun[2], 1'b0); end
    pps_train(2, 1000, 1);
    repeat (600) @(negedge i_clk_10);
    tests++; if (o_overrun[2] !== 1'b1) begin fails++; $display("FAIL overrun_set: got %b expected %b", o_overrun[2], 1'b1); end
    tests++; if (rise_n[2] !== 2) begin fails++; $display("FAIL overrun_count: got %0d expected %0d", rise_n[2], 2); end
    tests++; if (rise_tab[2][0] !== pps_r[0] + 1503) begin fails++; $display("FAIL overrun_rise0: got %0d expected %0d", rise_tab[2][0], pps_r[0] + 1503); end
    tests++; if (len_tab[2][0] !== 10) begin fails++; $display("FAIL overrun_len0: got %0d expected %0d", len_tab[2][0], 10); end
    tests++; if (rise_tab[2][1] !== pps_r[2] + 1503) begin fails++; $display("FAIL overrun_rise1: got %0d expected %0d", rise_tab[2][1], pps_r[2] + 1503); end
  endtask

  task automatic test_stop();
    do_reset();
    set_cfg(0, 1, 0, 5, 0);
    set_cfg(1, 1, 0, 5, 0);
    i_start = 4'b0011;
    repeat (5) @(negedge i_clk_10);
    pps_train(1, 30, 0);
    tests++; if (o_pps_div[1:0] !== 2'b11) begin fails++; $display("FAIL stop_pre: got %b expected %b", o_pps_div[1:0], 2'b11); end
    i_stop[0] = 1'b1;
    @(negedge i_clk_10);
    tests++; if (o_pps_div[0] !== 1'b0) begin fails++; $display("FAIL stop_out: got %b expected %b", o_pps_div[0], 1'b0); end
    tests++; if ({o_busy[0], o_done[0]} !== 2'b00) begin fails++; $display("FAIL stop_idle: got %b expected %b", {o_busy[0], o_done[0]}, 2'b00); end
    tests++; if ({o_pps_div[1], o_busy[1]} !== 2'b11) begin fails++; $display("FAIL stop_other: got %b expected %b", {o_pps_div[1], o_busy[1]}, 2'b11); end
    i_stop[0] = 1'b0;
    repeat (40) @(negedge i_clk_10);
    tests++; if (len_tab[0][0] !== 27) begin fails++; $display("FAIL stop_len0: got %0d expected %0d", len_tab[0][0], 27); end
    tests++; if (len_tab[1][0] !== 50) begin fails++; $display("FAIL stop_len1: got %0d expected %0d", len_tab[1][0], 50); end
    tests++; if (o_busy[0] !== 1'b1) begin fails++; $display("FAIL stop_rearm: got %b expected %b", o_busy[0], 1'b1); end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_cfg(0, 1, 0, 5, 0);
    i_start[0] = 1'b1;
    repeat (5) @(negedge i_clk_10);
    pps_train(1, 30, 0);
    tests++; if (o_pps_div[0] !== 1'b1) begin fails++; $display("FAIL areset_pre: got %b expected %b", o_pps_div[0], 1'b1); end
    #2 i_rst = 1'b0;
    #1;
    tests++; if (o_pps_div !== 4'b0) begin fails++; $display("FAIL areset_out: got %b expected %b", o_pps_div, 4'b0); end
    tests++; if (o_busy !== 4'b0) begin fails++; $display("FAIL areset_busy: got %b expected %b", o_busy, 4'b0); end
    @(negedge i_clk_10);
    i_rst = 1'b1;
    repeat (3) @(negedge i_clk_10);
    tests++; if (o_busy !== 4'b0001) begin fails++; $display("FAIL areset_arm: got %b expected %b", o_busy, 4'b0001); end
    tests++; if (o_pps_div !== 4'b0) begin fails++; $display("FAIL areset_quiet: got %b expected %b", o_pps_div, 4'b0); end
  endtask

  task automatic test_div0_width0();
    int r;
    do_reset();
    set_cfg(3, 0, 0, 0, 3);
    i_start[3] = 1'b1;
    repeat (5) @(negedge i_clk_10);
    pps_train(2, 100, 0);
    tests++; if (o_done[3] !== 1'b0) begin fails++; $display("FAIL zw_done_early: got %b expected %b", o_done[3], 1'b0); end
    @(negedge i_clk_10);
    r = cyc;
    i_pps_raw = 1'b1;
    repeat (3) @(negedge i_clk_10);
    tests++; if ({o_done[3], o_busy[3]} !== 2'b01) begin fails++; $display("FAIL zw_before: got %b expected %b", {o_done[3], o_busy[3]}, 2'b01); end
    @(negedge i_clk_10);
    tests++; if ({o_done[3], o_busy[3]} !== 2'b10) begin fails++; $display("FAIL zw_done: got %b expected %b at cycle %0d", {o_done[3], o_busy[3]}, 2'b10, r + 4); end
    i_pps_raw = 1'b0;
    repeat (5) @(negedge i_clk_10);
    tests++; if (rise_n[3] !== 0) begin fails++; $display("FAIL zw_no_pulse: got %0d expected %0d", rise_n[3], 0); end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_periodic();
    test_burst();
    test_overrun();
    test_stop();
    test_async_reset();
    test_div0_width0();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pps_divider_multi.md
Name: pps_divider_multi

Overview:
N-channel successor of the single-channel PPS divider, for the clock master fabric. One shared PPS synchroniser and rising-edge detector feeds N_CH independent divider channels. Each channel has its own division ratio, microsecond phase, pulse width, burst count and start/stop control, and reports busy, done and overrun status. Outputs drive the per-subsystem trigger lines.

Parameters:
N_CH, 4, number of divider channels
DATA_WIDTH, 8, width of div, width and burst fields (matches `DATA_WIDTH)
PHASE_WIDTH, 32, width of the phase field in µs
CLKS_PER_US, 10, i_clk_10 cycles per microsecond
SYNC_STAGES, 2, PPS synchroniser depth (minimum 2)

Ports:
i_clk_10  in  1  system clock, nominally 10 MHz
i_rst  in  1  reset, asynchronous, active-low
i_pps_raw  in  1  asynchronous PPS input
i_start  in  N_CH  per-channel arm level
i_stop  in  N_CH  per-channel stop level; dominates i_start
i_div_number  in  N_CH*DATA_WIDTH  fire on every D-th PPS edge
i_phase_us  in  N_CH*PHASE_WIDTH  delay from PPS edge to pulse, in µs
i_width_us  in  N_CH*DATA_WIDTH  pulse width in µs
i_burst_cnt  in  N_CH*DATA_WIDTH  0 = free-running periodic; n = n pulses, then hold
o_pps_div  out  N_CH  divided outputs, registered
o_busy  out  N_CH  channel is not in IDLE or DONE
o_done  out  N_CH  burst complete
o_overrun  out  N_CH  sticky; a firing edge was missed

Behaviour:
- Channel k uses field slice [k*W +: W] of each packed bus.
- Reset (i_rst=0, async): all outputs 0, all channels IDLE, all counters 0, synchroniser cleared.
- PPS path: SYNC_STAGES flops, then one edge flop. pps_edge is a 1-cycle pulse when the last two samples are 01. It is shared by all channels and never gated by channel start/stop.
- Channel FSM:
  - IDLE → ARM when i_start & ~i_stop.
  - ARM: on pps_edge, latch div, phase, width and burst into shadow registers; clear the edge counter. Go to PHASE if phase≠0, else to WIDTH.
  - PHASE: a prescaler counts 0..CLKS_PER_US-1. On each wrap, phase_ctr++. When phase_ctr reaches shadow phase, go to WIDTH.
  - WIDTH: o_pps_div=1 for exactly width*CLKS_PER_US cycles. Then pulses_ctr++.
    - If burst≠0 and pulses_ctr reaches burst, go to DONE.
    - Otherwise go to WAIT.
  - width=0: no pulse is emitted, but the firing still counts toward pulses_ctr.
  - WAIT: edge_ctr counts pps_edges since the last firing edge, including edges seen during PHASE and WIDTH. When edge_ctr reaches D (D=0 treated as 1), treat that edge as an ARM edge: re-latch the shadows and go to PHASE or WIDTH.
  - DONE: o_done=1 and the output stays low. Leave to IDLE on i_stop, or on deassertion of i_start.
- Latency: with phase=0, o_pps_div rises in the cycle after pps_edge. Otherwise it rises phase*CLKS_PER_US+1 cycles after pps_edge.
- Overrun: a firing edge can arrive while the channel is still in PHASE or WIDTH (edge_ctr reaches D there). In that case:
  - the current pulse completes unchanged;
  - o_overrun is set;
  - edge_ctr restarts at 0.
  - o_overrun is cleared only by reset or by the IDLE→ARM transition.
- Stop: i_stop=1 sends the channel to IDLE on the next clock edge. The output drops in the same cycle and the counters clear. If start and stop are asserted together, stop wins.
- Config changes take effect only at the next latch point (ARM exit or a firing edge in WAIT). They never take effect mid-pulse.
- Counter widths:
  - phase_ctr: PHASE_WIDTH bits.
  - width and edge counters: DATA_WIDTH bits.
  - prescaler: $clog2(CLKS_PER_US) bits.
  - No counter wraps; each compares with >= against its target.

Optional Feature:
PPS_DIVIDER_MULTI_INVERT_EN:
- When defined: adds input port i_invert (N_CH bits). o_pps_div[k] = pulse XOR i_invert[k], registered.
- Reset still forces o_pps_div to 0. The inverted idle level appears one cycle after reset release.
- When undefined: the port is absent and outputs are active-high only.

Decomposition:
- Shared package pps_div_pkg: channel state encodings, CLKS_PER_US default, slice-index helper function. DATA_WIDTH continues to come from address_map.vh.
- Natural sub-module: pps_div_channel (FSM, prescaler, counters, shadow registers, status).
- The top level holds the synchroniser and edge detector, plus a generate loop over N_CH channels.

Test Plan:
- Ch0: div=1, phase=0, width=5, burst=0; PPS every 1000 cycles. Required: 50-cycle pulse starting 1 cycle after each pps_edge, repeating indefinitely.
- Ch1: div=3, phase=2, width=1, burst=2. Required: 10-cycle pulses, each 21 cycles after edges 1 and 4; then o_done=1 and no further pulses; o_busy=0.
- Ch2: phase=150 µs, div=1, PPS period 1000 cycles. Required: second edge arrives during PHASE, o_overrun=1, the pulse still completes, and the next firing is on edge 3.
- Assert i_stop on ch0 mid-width. Required: output low next cycle; state IDLE; ch1–3 unaffected.
- Drive i_rst low asynchronously mid-pulse. Required: all outputs 0 immediately; after release, channels wait in IDLE/ARM.
- div=0, width=0, burst=3. Required: no pulses; o_done rises after the third PPS edge's firing.
